// File: rtl/formula_2_pipe_adapter.sv
// Host-side driver/collector for a fixed-latency, non-stallable formula pipe.
// Issues argument tuples under credit control and buffers results in an in-order FIFO.
module formula_2_pipe_adapter #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_vld,
  output logic        up_rdy,
  input  logic [31:0] up_a,
  input  logic [31:0] up_b,
  input  logic [31:0] up_c,
  output logic        arg_vld,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] c,
  input  logic        res_vld,
  input  logic [31:0] res,
  output logic        down_vld,
  input  logic        down_rdy,
  output logic [31:0] down_data,
  output logic        err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0] outstanding;
  logic [CW-1:0] inflight;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [31:0]   mem [DEPTH];

  logic accept;
  logic pop;
  logic empty;
  logic full;
  logic orphan;
  logic overflow;
  logic ret;
  logic wr_en;

  // Credit covers every result that can still land in the FIFO, so a legal pipe never overflows it.
  assign up_rdy   = (outstanding < CW'(DEPTH));
  assign accept   = up_vld && up_rdy;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign down_vld = !empty;
  assign pop      = down_vld && down_rdy;
  // Gated so the output reads 0 before any entry has been written.
  assign down_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // A result with nothing outstanding in the pipe, or with no room left, is a protocol error.
  assign orphan   = res_vld && (inflight == '0) && !arg_vld;
  assign overflow = res_vld && full && !pop;
  assign ret      = res_vld && !orphan;
  assign wr_en    = res_vld && !orphan && !overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      inflight    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      arg_vld     <= 1'b0;
      err         <= 1'b0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
    end else begin
      arg_vld <= accept;
      if (accept) begin
        a <= up_a;
        b <= up_b;
        c <= up_c;
      end

      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      case ({arg_vld, ret})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      wr_ptr <= wr_ptr + (AW+1)'(wr_en);
      rd_ptr <= rd_ptr + (AW+1)'(pop);

      if (orphan || overflow) err <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; only pointers define validity, and
  // leaving it unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= res;
  end

endmodule

// File: tb/tb_formula_2_pipe_adapter.sv
// Scoreboard bench for formula_2_pipe_adapter: a latency-5 pipe model feeds results back,
// and an independent monitor compares every popped result against the expected queue.
`timescale 1ns/1ps
module tb_formula_2_pipe_adapter;

  localparam int DEPTH = 8;
  localparam int LAT   = 5;

  logic        clk;
  logic        rst;
  logic        up_vld;
  logic        up_rdy;
  logic [31:0] up_a, up_b, up_c;
  logic        arg_vld;
  logic [31:0] a, b, c;
  logic        res_vld;
  logic [31:0] res;
  logic        down_vld;
  logic        down_rdy;
  logic [31:0] down_data;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  logic [31:0] exp_q[$];

  logic           inj = 1'b0;
  logic [LAT-1:0] dl_v;
  logic [31:0]    dl_d [LAT];

  formula_2_pipe_adapter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .up_vld(up_vld), .up_rdy(up_rdy), .up_a(up_a), .up_b(up_b), .up_c(up_c),
    .arg_vld(arg_vld), .a(a), .b(b), .c(c),
    .res_vld(res_vld), .res(res),
    .down_vld(down_vld), .down_rdy(down_rdy), .down_data(down_data),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The formula the bench pipe computes; 16*9+4+0x11A0 = 0x1234.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
    return x * y + z + 32'h11A0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fixed-latency pipe model, driven just after each rising edge.
  initial begin
    dl_v    = '0;
    res_vld = 1'b0;
    res     = '0;
  end
  always @(posedge clk) begin
    #1;
    res_vld = dl_v[LAT-1] | inj;
    res     = dl_v[LAT-1] ? dl_d[LAT-1] : 32'hDEAD_BEEF;
    inj     = 1'b0;
    for (int i = LAT-1; i > 0; i--) begin
      dl_v[i] = dl_v[i-1];
      dl_d[i] = dl_d[i-1];
    end
    dl_v[0] = arg_vld;
    dl_d[0] = model(a, b, c);
  end

  // Monitor: records accepts into the scoreboard and checks every pop.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (up_vld && up_rdy) begin
        exp_q.push_back(model(up_a, up_b, up_c));
        n_acc++;
      end
      if (down_vld && down_rdy) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", down_data, 32'h0);
          if (down_data == 32'h0) check("pop_unexpected_empty_q", 32'd1, 32'd0);
        end else begin
          check("pop_data", down_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drain();
    up_vld   = 1'b0;
    down_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (exp_q.size() == 0 && !down_vld) break;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    down_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int cnt;
    logic seen;

    rst = 1'b1; up_vld = 1'b0; down_rdy = 1'b0;
    up_a = '0; up_b = '0; up_c = '0;
    repeat (3) step();
    rst = 1'b0;

    @(negedge clk);
    check("rst_up_rdy",    32'(up_rdy),   32'd1);
    check("rst_down_vld",  32'(down_vld), 32'd0);
    check("rst_arg_vld",   32'(arg_vld),  32'd0);
    check("rst_err",       32'(err),      32'd0);
    check("rst_a",         a,             32'd0);
    check("rst_down_data", down_data,     32'd0);

    // Single tuple through the pipe.
    step();
    up_vld = 1'b1; up_a = 32'd16; up_b = 32'd9; up_c = 32'd4;
    step();
    up_vld = 1'b0;
    @(negedge clk);
    check("single_arg_vld", 32'(arg_vld), 32'd1);
    check("single_a", a, 32'd16);
    check("single_b", b, 32'd9);
    check("single_c", c, 32'd4);
    @(negedge clk);
    check("single_arg_pulse", 32'(arg_vld), 32'd0);
    cnt = 1;
    while (!res_vld && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("single_latency", 32'(cnt), 32'(LAT));
    check("single_no_bypass", 32'(down_vld), 32'd0);
    @(negedge clk);
    check("single_down_vld", 32'(down_vld), 32'd1);
    check("single_down_data", down_data, 32'h1234);
    step(); down_rdy = 1'b1;
    step(); down_rdy = 1'b0;
    @(negedge clk);
    check("single_popped", 32'(down_vld), 32'd0);
    check("single_credit", 32'(up_rdy), 32'd1);

    // Fill to credit limit with the host not consuming.
    start = n_acc;
    for (int i = 0; i < 20; i++) begin
      step();
      up_vld = 1'b1; up_a = $urandom; up_b = $urandom; up_c = $urandom;
    end
    @(negedge clk);
    check("fill_accepts", 32'(n_acc - start), 32'(DEPTH));
    check("fill_up_rdy", 32'(up_rdy), 32'd0);
    check("fill_down_vld", 32'(down_vld), 32'd1);
    check("fill_err", 32'(err), 32'd0);

    // One pop frees one credit; accept+pop together keep the count.
    step(); down_rdy = 1'b1;
    @(negedge clk);
    check("pop1_before", 32'(up_rdy), 32'd0);
    step(); down_rdy = 1'b0;
    @(negedge clk);
    check("pop1_after", 32'(up_rdy), 32'd1);
    step();
    @(negedge clk);
    check("refill_up_rdy", 32'(up_rdy), 32'd0);
    up_vld = 1'b0;
    step(); down_rdy = 1'b1;
    step(); up_vld = 1'b1;
    @(negedge clk);
    check("both_pre_up_rdy", 32'(up_rdy), 32'd1);
    step(); up_vld = 1'b0; down_rdy = 1'b0;
    @(negedge clk);
    check("both_post_up_rdy", 32'(up_rdy), 32'd1);
    step(); up_vld = 1'b1;
    step(); up_vld = 1'b0;
    @(negedge clk);
    check("last_credit_up_rdy", 32'(up_rdy), 32'd0);
    check("credit_err", 32'(err), 32'd0);
    drain();

    // Random streaming.
    start = n_acc;
    for (int cyc = 0; cyc < 20000 && (n_acc - start) < 1000; cyc++) begin
      step();
      up_vld   = ($urandom_range(0, 3) != 0);
      down_rdy = ($urandom_range(0, 2) != 0);
      up_a = $urandom; up_b = $urandom; up_c = $urandom;
    end
    check("random_count", 32'((n_acc - start) >= 1000), 32'd1);
    drain();
    check("random_err", 32'(err), 32'd0);

    // Orphan result sets the sticky error.
    repeat (10) step();
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    check("orphan_res_vld", 32'(res_vld), 32'd1);
    check("orphan_err_before", 32'(err), 32'd0);
    @(negedge clk);
    check("orphan_err", 32'(err), 32'd1);
    check("orphan_no_data", 32'(down_vld), 32'd0);
    repeat (5) @(negedge clk);
    check("orphan_sticky", 32'(err), 32'd1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check("orphan_cleared", 32'(err), 32'd0);

    // Reset with tuples in flight; stale results must raise err only.
    step(); up_vld = 1'b1; up_a = $urandom; up_b = $urandom; up_c = $urandom;
    step(); up_a = $urandom;
    step(); up_a = $urandom;
    step(); up_vld = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check("midrst_down_vld", 32'(down_vld), 32'd0);
    check("midrst_up_rdy", 32'(up_rdy), 32'd1);
    check("midrst_err", 32'(err), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (down_vld) seen = 1'b1;
    end
    check("stale_no_down_vld", 32'(seen), 32'd0);
    check("stale_err", 32'(err), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
